lpd_rom_arbiter: RTL and testbench

- Shares one single-port pattern ROM (1024 x 10-bit words) between two pattern-detector requesters. Each requester scans the ROM by address.
- Round-robin grant with a bounded burst length, one-cycle ROM read latency, per-requester read-valid tagging and out-of-range address protection.
- Sits between two detector instances and the ROM macro. Also aggregates the detectors' finish signals into a single completion flag.

---
 rtl/lpd_pkg.sv | 28 ++
 rtl/lpd_rr_pick.sv | 24 ++
 rtl/lpd_rom_arbiter.sv | 141 ++++++++++++++
 tb/tb_lpd_rom_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpd_pkg.sv
// Shared constants and types for the pattern-ROM arbiter slice.
package lpd_pkg;

  localparam int unsigned LPD_ADDR_W    = 10;
  localparam int unsigned LPD_DATA_W    = 10;
  localparam int unsigned LPD_ROM_DEPTH = 1024;
  localparam int unsigned LPD_BURST_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  // Tag travelling alongside a ROM access into the data-return cycle
  typedef struct packed {
    logic v0;
    logic v1;
    logic oob;
  } rd_tag_t;

  function automatic arb_state_e own_state(input req_id_t id);
    return id ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/lpd_rr_pick.sv
// Two-way round-robin chooser: favoured side wins a tie unless its burst has expired.
module lpd_rr_pick
  import lpd_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    favour,
  input  logic       burst_expired,
  output logic [1:0] gnt_c
);

  req_id_t pick;

  always_comb begin
    gnt_c = 2'b00;
    pick  = favour ^ burst_expired;
    unique case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = pick ? 2'b10 : 2'b01;
      default: gnt_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/lpd_rom_arbiter.sv
// Shares one single-port pattern ROM between two detector requesters with
// bounded-burst round-robin, tagged read return, range protection and done aggregation.
module lpd_rom_arbiter
  import lpd_pkg::*;
#(
  parameter int unsigned ADDR_W    = LPD_ADDR_W,
  parameter int unsigned DATA_W    = LPD_DATA_W,
  parameter int unsigned ROM_DEPTH = LPD_ROM_DEPTH,
  parameter int unsigned BURST_MAX = LPD_BURST_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              done1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              oob_err,
  output logic              all_done
);

  localparam int unsigned BEAT_W = $clog2(BURST_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  req_id_t           prio_q, prio_d;
  rd_tag_t           rd_q, rd_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              all_done_q, all_done_d;

  logic [1:0]        req_v;
  logic [1:0]        gnt_v;
  req_id_t           favour;
  req_id_t           gnt_id;
  logic              burst_expired;
  logic              granted;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;

  // Arbitration inputs; requests are masked so nothing is granted during reset
  always_comb begin : arb_inputs
    req_v         = {req1, req0} & {2{rst_n}};
    favour        = prio_q;
    if (state_q == ST_OWN0) begin
      favour = 1'b0;
    end else if (state_q == ST_OWN1) begin
      favour = 1'b1;
    end
    burst_expired = (state_q != ST_IDLE) && (32'(beat_q) >= BURST_MAX);
  end

  lpd_rr_pick u_pick (
    .req           (req_v),
    .favour        (favour),
    .burst_expired (burst_expired),
    .gnt_c         (gnt_v)
  );

  assign granted  = |gnt_v;
  assign gnt_id   = gnt_v[1];
  assign sel_addr = gnt_v[0] ? addr0 : addr1;

  // A ROM that covers the whole address space needs no range compare
  if (64'(ROM_DEPTH) >= (64'(1) << ADDR_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = sel_addr < ADDR_W'(ROM_DEPTH);
  end

  assign gnt0     = gnt_v[0];
  assign gnt1     = gnt_v[1];
  assign rom_addr = sel_addr;
  assign rom_en   = granted & in_range;

  always_comb begin : fsm_next
    state_d = state_q;
    beat_d  = beat_q;
    prio_d  = prio_q;
    if (!granted) begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end else begin
      state_d = own_state(gnt_id);
      if (state_d == state_q) begin
        if (32'(beat_q) < BURST_MAX) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end else begin
        beat_d = BEAT_W'(1);
        prio_d = ~gnt_id;
      end
    end
  end

  always_comb begin : rd_done_next
    rd_d.v0    = gnt_v[0];
    rd_d.v1    = gnt_v[1];
    rd_d.oob   = granted & ~in_range;
    done0_d    = done0_q | done0;
    done1_d    = done1_q | done1;
    all_done_d = done0_d & done1_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      prio_q     <= 1'b0;
      rd_q       <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      prio_q     <= prio_d;
      rd_q       <= rd_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      all_done_q <= all_done_d;
    end
  end

  // ROM data arrives the cycle after the grant, so the return mux uses the registered tag
  assign rdata    = ((rd_q.v0 | rd_q.v1) & ~rd_q.oob) ? rom_rdata : '0;
  assign rvalid0  = rd_q.v0;
  assign rvalid1  = rd_q.v1;
  assign oob_err  = rd_q.oob;
  assign all_done = all_done_q;

endmodule

// File: tb/tb_lpd_rom_arbiter.sv
// Self-checking bench for lpd_rom_arbiter: cycle-level reference model plus directed literal checks.
module tb_lpd_rom_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 10;
  localparam int DEPTH = 1024;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, done0, done1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata;
  logic [DW-1:0] rdata;
  logic          rvalid0, rvalid1, oob_err, all_done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rom_mem [DEPTH];

  int pat_burst [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int exp_seq   [8] = '{341, 340, 343, 342, 337, 336, 339, 338};

  // Reference model state
  int m_owner, m_run, m_tie;
  int m_v0, m_v1, m_oob, m_rdata;
  int m_l0, m_l1, m_all;

  lpd_rom_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ROM_DEPTH (DEPTH),
    .BURST_MAX (BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .addr0     (addr0),
    .done0     (done0),
    .req1      (req1),
    .addr1     (addr1),
    .done1     (done1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .rdata     (rdata),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .oob_err   (oob_err),
    .all_done  (all_done)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'(i ^ 'h155);
  end

  // ROM macro: one-cycle read latency
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom_mem[rom_addr[9:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) begin
      if (m_owner < 0) return m_tie;
      if (m_run < BURST) return m_owner;
      return 1 - m_owner;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Per-cycle comparison against the reference model
  initial begin : compare
    int g;
    int ina;
    int inr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rom_en", 32'(rom_en), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rvalid1", 32'(rvalid1), 0);
        chk("rst_oob", 32'(oob_err), 0);
        chk("rst_all_done", 32'(all_done), 0);
        m_owner = -1; m_run = 0; m_tie = 0;
        m_v0 = 0; m_v1 = 0; m_oob = 0; m_rdata = 0;
        m_l0 = 0; m_l1 = 0; m_all = 0;
      end else begin
        g   = pick(req0, req1);
        ina = (g == 0) ? int'(addr0) : int'(addr1);
        inr = (ina < DEPTH) ? 1 : 0;
        chk("m_gnt0", 32'(gnt0), 32'(g == 0));
        chk("m_gnt1", 32'(gnt1), 32'(g == 1));
        chk("m_gnt_excl", 32'(gnt0 & gnt1), 0);
        chk("m_rom_en", 32'(rom_en), 32'(g >= 0 && inr == 1));
        if (g >= 0) chk("m_rom_addr", 32'(rom_addr), 32'(ina));
        chk("m_rvalid0", 32'(rvalid0), 32'(m_v0));
        chk("m_rvalid1", 32'(rvalid1), 32'(m_v1));
        chk("m_oob", 32'(oob_err), 32'(m_oob));
        chk("m_all_done", 32'(all_done), 32'(m_all));
        if (m_v0 == 1 || m_v1 == 1) chk("m_rdata", 32'(rdata), 32'(m_rdata));
        m_v0    = (g == 0) ? 1 : 0;
        m_v1    = (g == 1) ? 1 : 0;
        m_oob   = (g >= 0 && inr == 0) ? 1 : 0;
        m_rdata = (inr == 1) ? int'(rom_mem[ina]) : 0;
        if (g < 0) begin
          m_owner = -1;
          m_run   = 0;
        end else if (g == m_owner) begin
          m_run = (m_run < BURST) ? m_run + 1 : BURST;
        end else begin
          m_tie   = 1 - g;
          m_owner = g;
          m_run   = 1;
        end
        if (done0) m_l0 = 1;
        if (done1) m_l1 = 1;
        m_all = m_l0 & m_l1;
      end
    end
  end

  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic r1,
                       input logic [AW-1:0] a1, input logic d0, input logic d1);
    @(posedge clk);
    #1;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; done0 = d0; done1 = d1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    req0 = 0; req1 = 0; done0 = 0; done1 = 0; addr0 = '0; addr1 = '0;
    repeat (2) @(posedge clk);
    #1;
    req0 = 1; addr0 = 11'd5;
    settle();
    chk("lit_reset_gnt0", 32'(gnt0), 0);
    chk("lit_reset_rom_en", 32'(rom_en), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req0 = 0;

    // Single requester scanning addresses 0..7
    for (int a = 0; a < 8; a++) begin
      drive(1, AW'(a), 0, '0, 0, 0);
      settle();
      chk("lit_seq_gnt0", 32'(gnt0), 1);
      chk("lit_seq_gnt1", 32'(gnt1), 0);
      if (a > 0) begin
        chk("lit_seq_rvalid0", 32'(rvalid0), 1);
        chk("lit_seq_rdata", 32'(rdata), 32'(exp_seq[a-1]));
      end
    end
    drive(0, '0, 0, '0, 0, 0);
    settle();
    chk("lit_seq_rvalid0_last", 32'(rvalid0), 1);
    chk("lit_seq_rdata_last", 32'(rdata), 32'(exp_seq[7]));

    // Both requesting from reset: bursts of four
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0 = 1; req1 = 1; addr0 = 11'd10; addr1 = 11'd20;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      settle();
      chk("lit_burst_gnt1", 32'(gnt1), 32'(pat_burst[i]));
      chk("lit_burst_gnt0", 32'(gnt0), 32'(1 - pat_burst[i]));
    end

    // Owner drops its request while the other waits
    drive(0, '0, 0, '0, 0, 0);
    drive(1, 11'd1, 0, '0, 0, 0);
    drive(1, 11'd2, 1, 11'd30, 0, 0);
    settle();
    chk("lit_drop_pre_gnt0", 32'(gnt0), 1);
    drive(0, '0, 1, 11'd31, 0, 0);
    settle();
    chk("lit_drop_gnt1", 32'(gnt1), 1);
    chk("lit_drop_gnt0", 32'(gnt0), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 11'd3, 1, AW'(32 + i), 0, 0);
      settle();
      chk("lit_drop_run_gnt1", 32'(gnt1), 1);
    end
    drive(1, 11'd3, 1, 11'd40, 0, 0);
    settle();
    chk("lit_drop_switch_gnt0", 32'(gnt0), 1);

    // Range boundary on requester 1
    drive(0, '0, 1, 11'd1023, 0, 0);
    settle();
    chk("lit_oob_en_1023", 32'(rom_en), 1);
    drive(0, '0, 1, 11'd1024, 0, 0);
    settle();
    chk("lit_oob_rv_1023", 32'(rvalid1), 1);
    chk("lit_oob_rdata_1023", 32'(rdata), 682);
    chk("lit_oob_err_1023", 32'(oob_err), 0);
    chk("lit_oob_en_1024", 32'(rom_en), 0);
    drive(0, '0, 1, 11'd1025, 0, 0);
    settle();
    chk("lit_oob_rv_1024", 32'(rvalid1), 1);
    chk("lit_oob_rdata_1024", 32'(rdata), 0);
    chk("lit_oob_err_1024", 32'(oob_err), 1);
    chk("lit_oob_en_1025", 32'(rom_en), 0);
    drive(0, '0, 0, '0, 0, 0);
    settle();
    chk("lit_oob_rv_1025", 32'(rvalid1), 1);
    chk("lit_oob_rdata_1025", 32'(rdata), 0);
    chk("lit_oob_err_1025", 32'(oob_err), 1);
    drive(0, '0, 0, '0, 0, 0);
    settle();
    chk("lit_oob_err_clear", 32'(oob_err), 0);

    // done0 then done1 ten cycles later
    drive(0, '0, 0, '0, 1, 0);
    settle();
    chk("lit_done_c10", 32'(all_done), 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, '0, 0, '0, 0, 0);
      settle();
      chk("lit_done_wait", 32'(all_done), 0);
    end
    drive(0, '0, 0, '0, 0, 1);
    settle();
    chk("lit_done_c20", 32'(all_done), 0);
    drive(0, '0, 0, '0, 0, 0);
    settle();
    chk("lit_done_c21", 32'(all_done), 1);
    drive(0, '0, 0, '0, 0, 0);
    settle();
    chk("lit_done_sticky", 32'(all_done), 1);

    // Reset in the cycle after a grant
    drive(1, 11'd3, 1, 11'd4, 0, 0);
    settle();
    chk("lit_mb_grant", 32'(gnt0 | gnt1), 1);
    @(posedge clk);
    #1;
    chk("lit_mb_rv_pre", 32'(rvalid0 | rvalid1), 1);
    rst_n = 1'b0;
    #1;
    chk("lit_mb_rv0", 32'(rvalid0), 0);
    chk("lit_mb_rv1", 32'(rvalid1), 0);
    chk("lit_mb_oob", 32'(oob_err), 0);
    chk("lit_mb_all_done", 32'(all_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    chk("lit_mb_first_gnt0", 32'(gnt0), 1);
    chk("lit_mb_first_gnt1", 32'(gnt1), 0);
    chk("lit_mb_no_stale0", 32'(rvalid0), 0);
    chk("lit_mb_no_stale1", 32'(rvalid1), 0);

    // Simultaneous done
    drive(0, '0, 0, '0, 1, 1);
    settle();
    chk("lit_sim_done_same", 32'(all_done), 0);
    drive(0, '0, 0, '0, 0, 0);
    settle();
    chk("lit_sim_done_next", 32'(all_done), 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
